// File: rtl/jtcps_snd_pkg.sv
// Shared constants for the CPS sound-CPU bus decoder.
// Holds the Z80 memory-map page codes, the banked-ROM base/size and the
// IO select codes taken from A[3:1] inside the IO page.
package jtcps_snd_pkg;

  // A[15:12] page codes
  localparam logic [3:0] RAM_PAGE  = 4'hD;
  localparam logic [3:0] IO_PAGE   = 4'hF;
  // A[15:14] code of the banked ROM window (8000-BFFF)
  localparam logic [1:0] BANK_PAGE = 2'b10;

  // Banked window lands right after the 32 kB fixed ROM
  localparam int unsigned BANK_BASE = 32'h8000;
  localparam int unsigned BANK_SIZE = 32'h4000;

  // IO select codes on A[3:1]; latch i uses IO_LATCH + i
  typedef enum logic [2:0] {
    IO_FM    = 3'd0,
    IO_OKI   = 3'd1,
    IO_BANK  = 3'd2,
    IO_SS    = 3'd3,
    IO_LATCH = 3'd4
  } io_code_e;

  function automatic logic [31:0] bank_addr(input logic [3:0] bank, input logic [13:0] offset);
    return BANK_BASE + 32'(bank) * BANK_SIZE + 32'(offset);
  endfunction

endpackage

// File: rtl/jtcps_sndlatch.sv
// Main-to-sound command latches with pending flags.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cen, rd_n           Z80 clock enable and read strobe
//   sel[NLATCH]         registered latch selects from the bus decoder
//   latch_data/latch_wr main-CPU data and one-clk write strobes
//   latch_pend          per-latch "unread data" flag
//   dout, hit           data of the selected latch, any latch selected
//   nmi_n               sound-CPU NMI (only driven when JTCPS_SNDBUS_NMI_EN
//                       is defined, otherwise tied high)
module jtcps_sndlatch #(
  parameter int NLATCH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cen,
  input  logic                  rd_n,
  input  logic [NLATCH-1:0]     sel,
  input  logic [8*NLATCH-1:0]   latch_data,
  input  logic [NLATCH-1:0]     latch_wr,
  output logic [NLATCH-1:0]     latch_pend,
  output logic [7:0]            dout,
  output logic                  hit,
  output logic                  nmi_n
);

  logic [7:0] data_reg [NLATCH];

  // A main-side write takes precedence over a simultaneous clearing read,
  // so the fresh command is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latch_pend <= '0;
      for (int i = 0; i < NLATCH; i++) data_reg[i] <= 8'h00;
    end else begin
      for (int i = 0; i < NLATCH; i++) begin
        if (latch_wr[i]) begin
          data_reg[i]   <= latch_data[8*i +: 8];
          latch_pend[i] <= 1'b1;
        end else if (cen && !rd_n && sel[i]) begin
          latch_pend[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    dout = 8'h00;
    for (int i = 0; i < NLATCH; i++) begin
      if (sel[i]) dout = data_reg[i];
    end
  end

  assign hit = |sel;

`ifdef JTCPS_SNDBUS_NMI_EN
  assign nmi_n = ~|latch_pend;
`else
  assign nmi_n = 1'b1;
`endif

endmodule

// File: rtl/jtcps_sndbus.sv
// CPS sound-CPU (Z80) bus decoder.
// Decodes fixed/banked ROM, RAM, FM/OKI devices, bank and OKI-ss registers
// and the main-to-sound command latches; stalls the CPU through cpu_cen
// until ROM data has been stable for two clocks.
// Ports:
//   clk, rst                      48 MHz clock, asynchronous active-high reset
//   cen / cpu_cen                 Z80 clock enable in / gated enable out
//   A, mreq_n, rd_n, wr_n, cpu_dout, cpu_din   Z80 bus
//   latch_data, latch_wr, latch_pend           main-CPU command latches
//   nmi_n                         sound-CPU NMI
//   fm_cs, oki_cs, fm_dout, oki_dout, oki_ss, dev_wrn   sound devices
//   ram_addr, ram_we, ram_dout    sound RAM
//   rom_addr, rom_cs, rom_data, rom_ok         ROM fetch interface
// Option: define JTCPS_SNDBUS_NMI_EN to raise NMI while a latch is pending.
module jtcps_sndbus
  import jtcps_snd_pkg::*;
#(
  parameter int NLATCH = 2,
  parameter int BANKW  = 1,
  parameter int RAMAW  = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cen,
  output logic                  cpu_cen,
  input  logic [15:0]           A,
  input  logic                  mreq_n,
  input  logic                  rd_n,
  input  logic                  wr_n,
  input  logic [7:0]            cpu_dout,
  output logic [7:0]            cpu_din,
  input  logic [8*NLATCH-1:0]   latch_data,
  input  logic [NLATCH-1:0]     latch_wr,
  output logic [NLATCH-1:0]     latch_pend,
  output logic                  nmi_n,
  output logic                  fm_cs,
  output logic                  oki_cs,
  input  logic [7:0]            fm_dout,
  input  logic [7:0]            oki_dout,
  output logic                  oki_ss,
  output logic                  dev_wrn,
  output logic [RAMAW-1:0]      ram_addr,
  output logic                  ram_we,
  input  logic [7:0]            ram_dout,
  output logic [15+BANKW-1:0]   rom_addr,
  output logic                  rom_cs,
  input  logic [7:0]            rom_data,
  input  logic                  rom_ok
);

  localparam int ROMAW = 15 + BANKW;

  logic [BANKW-1:0]  bank_reg;
  logic              rom_cs_next, ram_cs_next, fm_cs_next, oki_cs_next;
  logic              bank_cs_next, ss_cs_next, io_hit;
  logic [ROMAW-1:0]  rom_addr_next;
  logic [NLATCH-1:0] lsel_next, lsel_reg;
  logic              ram_cs_reg, bank_cs_reg, ss_cs_reg;
  logic              ok1_reg, ok2_reg, rom_restart, rom_wait;
  logic [7:0]        lat_dout;
  logic              lat_hit;
  logic              dev_hit_reg, lat_hit_reg, mem_hit_reg;
  logic [7:0]        dev_data_reg, lat_data_reg, mem_data_reg;
  io_code_e          io_code;
  logic              unused_dout;

  // Only the low bits of cpu_dout are consumed by the bank/ss registers;
  // RAM write data reaches the RAM directly from the CPU.
  assign unused_dout = ^cpu_dout;

  always_comb begin
    io_code       = io_code_e'(A[3:1]);
    io_hit        = ~mreq_n & (A[15:12] == IO_PAGE);
    rom_cs_next   = ~mreq_n & ~rd_n & (~A[15] | (A[15:14] == BANK_PAGE));
    rom_addr_next = A[15] ? ROMAW'(bank_addr(4'(bank_reg), A[13:0]))
                          : ROMAW'(A[14:0]);
    ram_cs_next   = ~mreq_n & (A[15:12] == RAM_PAGE);
    fm_cs_next    = io_hit & (io_code == IO_FM);
    oki_cs_next   = io_hit & (io_code == IO_OKI);
    bank_cs_next  = io_hit & (io_code == IO_BANK);
    ss_cs_next    = io_hit & (io_code == IO_SS);
  end

  for (genvar gi = 0; gi < NLATCH; gi++) begin : g_lsel
    assign lsel_next[gi] = io_hit & (int'(A[3:1]) == int'(IO_LATCH) + gi);
  end

  // A new ROM access (first cycle or address change) must see rom_ok
  // afresh, so stale "ok" history from the previous fetch is discarded.
  assign rom_restart = rom_cs_next & (~rom_cs | (rom_addr_next != rom_addr));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_cs      <= 1'b0;
      rom_addr    <= '0;
      ram_cs_reg  <= 1'b0;
      ram_addr    <= '0;
      fm_cs       <= 1'b0;
      oki_cs      <= 1'b0;
      bank_cs_reg <= 1'b0;
      ss_cs_reg   <= 1'b0;
      lsel_reg    <= '0;
      bank_reg    <= '0;
      oki_ss      <= 1'b0;
      ok1_reg     <= 1'b0;
      ok2_reg     <= 1'b0;
    end else begin
      rom_cs      <= rom_cs_next;
      rom_addr    <= rom_addr_next;
      ram_cs_reg  <= ram_cs_next;
      ram_addr    <= A[RAMAW-1:0];
      fm_cs       <= fm_cs_next;
      oki_cs      <= oki_cs_next;
      bank_cs_reg <= bank_cs_next;
      ss_cs_reg   <= ss_cs_next;
      lsel_reg    <= lsel_next;
      if (cen && !wr_n) begin
        if (bank_cs_reg) bank_reg <= cpu_dout[BANKW-1:0];
        if (ss_cs_reg)   oki_ss   <= cpu_dout[0];
      end
      if (rom_restart) begin
        ok1_reg <= 1'b0;
        ok2_reg <= 1'b0;
      end else begin
        ok1_reg <= rom_cs & rom_ok;
        ok2_reg <= ok1_reg & rom_cs & rom_ok;
      end
    end
  end

  assign rom_wait = rom_cs & ~ok2_reg;
  assign cpu_cen  = cen & ~rom_wait;
  assign dev_wrn  = ~((fm_cs | oki_cs) & ~wr_n & ~mreq_n);
  assign ram_we   = ram_cs_reg & ~wr_n & ~mreq_n;

  jtcps_sndlatch #(.NLATCH(NLATCH)) u_latch (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .rd_n       (rd_n),
    .sel        (lsel_reg),
    .latch_data (latch_data),
    .latch_wr   (latch_wr),
    .latch_pend (latch_pend),
    .dout       (lat_dout),
    .hit        (lat_hit),
    .nmi_n      (nmi_n)
  );

  // Read path: first stage captures each source class, second stage picks
  // device > latch > memory, open bus reads as FF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dev_hit_reg  <= 1'b0;
      lat_hit_reg  <= 1'b0;
      mem_hit_reg  <= 1'b0;
      dev_data_reg <= 8'hFF;
      lat_data_reg <= 8'hFF;
      mem_data_reg <= 8'hFF;
      cpu_din      <= 8'hFF;
    end else begin
      dev_hit_reg  <= fm_cs | oki_cs;
      dev_data_reg <= fm_cs ? fm_dout : oki_dout;
      lat_hit_reg  <= lat_hit;
      lat_data_reg <= lat_dout;
      mem_hit_reg  <= rom_cs | ram_cs_reg;
      mem_data_reg <= rom_cs ? rom_data : ram_dout;
      if (dev_hit_reg)      cpu_din <= dev_data_reg;
      else if (lat_hit_reg) cpu_din <= lat_data_reg;
      else if (mem_hit_reg) cpu_din <= mem_data_reg;
      else                  cpu_din <= 8'hFF;
    end
  end

endmodule

// File: tb/tb_jtcps_sndbus.sv
// Directed bench for jtcps_sndbus (NLATCH=2, BANKW=2, RAMAW=11).
module tb_jtcps_sndbus;

  localparam int NLATCH = 2;
  localparam int BANKW  = 2;
  localparam int RAMAW  = 11;
`ifdef JTCPS_SNDBUS_NMI_EN
  localparam logic NMI_EN = 1'b1;
`else
  localparam logic NMI_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst, cen, cpu_cen;
  logic [15:0]         A;
  logic                mreq_n, rd_n, wr_n;
  logic [7:0]          cpu_dout, cpu_din;
  logic [8*NLATCH-1:0] latch_data;
  logic [NLATCH-1:0]   latch_wr, latch_pend;
  logic                nmi_n, fm_cs, oki_cs, oki_ss, dev_wrn;
  logic [7:0]          fm_dout, oki_dout, ram_dout, rom_data;
  logic [RAMAW-1:0]    ram_addr;
  logic                ram_we, rom_cs, rom_ok;
  logic [15+BANKW-1:0] rom_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  jtcps_sndbus #(.NLATCH(NLATCH), .BANKW(BANKW), .RAMAW(RAMAW)) dut (
    .clk(clk), .rst(rst), .cen(cen), .cpu_cen(cpu_cen),
    .A(A), .mreq_n(mreq_n), .rd_n(rd_n), .wr_n(wr_n),
    .cpu_dout(cpu_dout), .cpu_din(cpu_din),
    .latch_data(latch_data), .latch_wr(latch_wr), .latch_pend(latch_pend),
    .nmi_n(nmi_n), .fm_cs(fm_cs), .oki_cs(oki_cs),
    .fm_dout(fm_dout), .oki_dout(oki_dout), .oki_ss(oki_ss), .dev_wrn(dev_wrn),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_dout(ram_dout),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("chk  %s = 0x%0h ok", tag, got);
    end
  endtask

  // Advance one clock; inputs are then driven and outputs sampled 2 ns later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic bus_idle();
    mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; cen = 1'b1; A = 16'h0000; bus_idle(); cpu_dout = 8'h00;
    latch_data = '0; latch_wr = '0;
    fm_dout = 8'h00; oki_dout = 8'h00; ram_dout = 8'h00; rom_data = 8'h00; rom_ok = 1'b0;
    #12;
    // reset state
    check_val("rst_cpu_din", 32'(cpu_din), 32'hFF);
    check_val("rst_nmi_n", 32'(nmi_n), 32'h1);
    check_val("rst_dev_wrn", 32'(dev_wrn), 32'h1);
    check_val("rst_ram_we", 32'(ram_we), 32'h0);
    check_val("rst_pend", 32'(latch_pend), 32'h0);
    check_val("rst_cs", 32'({rom_cs, fm_cs, oki_cs, oki_ss}), 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // bank <= 3 via F004, then banked read of 8123
    A = 16'hF004; mreq_n = 1'b0; wr_n = 1'b0; cpu_dout = 8'h03;
    tick(); tick();
    bus_idle();
    tick();
    A = 16'h8123; mreq_n = 1'b0; rd_n = 1'b0;
    tick();
    check_val("bank_rom_cs", 32'(rom_cs), 32'h1);
    check_val("bank_rom_addr", 32'(rom_addr), 32'h14123);
    check_val("wait_cen_0", 32'(cpu_cen), 32'h0);
    for (int i = 1; i < 10; i++) begin
      tick();
      check_val($sformatf("wait_cen_%0d", i), 32'(cpu_cen), 32'h0);
    end
    rom_ok = 1'b1; rom_data = 8'hA5;
    tick();
    check_val("wait_ok_1clk", 32'(cpu_cen), 32'h0);
    tick();
    check_val("wait_ok_2clk", 32'(cpu_cen), 32'h1);
    check_val("rom_din", 32'(cpu_din), 32'hA5);

    // fixed region, then reset during the ROM wait
    A = 16'h1234; rom_ok = 1'b0;
    tick();
    check_val("fix_rom_addr", 32'(rom_addr), 32'h01234);
    check_val("fix_wait", 32'(cpu_cen), 32'h0);
    tick();
    rst = 1'b1;
    #1;
    check_val("rstw_rom_cs", 32'(rom_cs), 32'h0);
    check_val("rstw_cpu_cen", 32'(cpu_cen), 32'h1);
    check_val("rstw_cpu_din", 32'(cpu_din), 32'hFF);
    check_val("rstw_misc", 32'({nmi_n, dev_wrn, ram_we, oki_ss, latch_pend}), 32'b11000_0);
    tick();
    rst = 1'b0; A = 16'h8123;
    tick();
    check_val("rstr_rom_addr", 32'(rom_addr), 32'h08123);
    check_val("rstr_wait", 32'(cpu_cen), 32'h0);
    rom_ok = 1'b1;
    tick(); tick();
    check_val("rstr_resume", 32'(cpu_cen), 32'h1);
    bus_idle(); rom_ok = 1'b0;
    tick();

    // latch 1 write and Z80 read of F00A
    latch_data = {8'h5A, 8'h00}; latch_wr = 2'b10;
    tick();
    latch_wr = 2'b00;
    check_val("l1_pend", 32'(latch_pend), 32'h2);
    check_val("l1_nmi_n", 32'(nmi_n), 32'(!NMI_EN));
    A = 16'hF00A; mreq_n = 1'b0; rd_n = 1'b0;
    tick(); tick(); tick();
    check_val("l1_din", 32'(cpu_din), 32'h5A);
    check_val("l1_pend_clr", 32'(latch_pend), 32'h0);
    check_val("l1_nmi_clr", 32'(nmi_n), 32'h1);
    tick(); tick();
    check_val("l1_reread", 32'(cpu_din), 32'h5A);
    bus_idle();
    tick();

    // latch 0: write coinciding with the clearing read of F008
    latch_data = {8'h5A, 8'h11}; latch_wr = 2'b01;
    tick();
    latch_wr = 2'b00;
    A = 16'hF008; mreq_n = 1'b0; rd_n = 1'b0;
    tick();
    latch_data = {8'h5A, 8'h77}; latch_wr = 2'b01;
    tick();
    latch_wr = 2'b00; bus_idle();
    check_val("l0_race_pend", 32'(latch_pend), 32'h1);
    tick();
    mreq_n = 1'b0; rd_n = 1'b0;
    tick(); tick(); tick();
    check_val("l0_new_data", 32'(cpu_din), 32'h77);
    check_val("l0_pend_clr", 32'(latch_pend), 32'h0);

    // unmapped IO and device reads
    A = 16'hF00E;
    tick(); tick(); tick();
    check_val("unmapped_din", 32'(cpu_din), 32'hFF);
    A = 16'hF000; fm_dout = 8'h3C;
    tick(); tick(); tick();
    check_val("fm_din", 32'(cpu_din), 32'h3C);

    // device write to F002
    A = 16'hF002; rd_n = 1'b1; wr_n = 1'b0;
    tick();
    check_val("oki_cs", 32'(oki_cs), 32'h1);
    check_val("oki_fm_cs", 32'(fm_cs), 32'h0);
    check_val("oki_dev_wrn", 32'(dev_wrn), 32'h0);
    wr_n = 1'b1;
    #1;
    check_val("oki_wrn_end", 32'(dev_wrn), 32'h1);

    // RAM write and read at D010
    A = 16'hD010; wr_n = 1'b0;
    tick();
    check_val("ram_we", 32'(ram_we), 32'h1);
    check_val("ram_addr", 32'(ram_addr), 32'h010);
    wr_n = 1'b1; rd_n = 1'b0; ram_dout = 8'h99;
    tick(); tick(); tick();
    check_val("ram_din", 32'(cpu_din), 32'h99);

    // oki_ss register at F006
    A = 16'hF006; rd_n = 1'b1; wr_n = 1'b0; cpu_dout = 8'h01;
    tick(); tick();
    check_val("oki_ss", 32'(oki_ss), 32'h1);
    bus_idle();

    // cen gating
    cen = 1'b0;
    #1;
    check_val("cen_gate", 32'(cpu_cen), 32'h0);
    cen = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtcps_sndbus.md
JTCPS_SNDBUS -- requirements
Module: jtcps_sndbus

Interface
REQ-001 SHALL have parameter NLATCH, default 2, number of main-to-sound command latches (1..4).
REQ-002 SHALL have parameter BANKW, default 1, width of the ROM bank register (1..4).
REQ-003 SHALL have parameter RAMAW, default 11, sound RAM address width.
REQ-004 SHALL have port clk  in  1  system clock (48 MHz); reset rst, asynchronous, active-high.
REQ-005 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-006 SHALL have ports cen in 1 (Z80 clock enable) and cpu_cen out 1 (gated enable to the CPU).
REQ-007 SHALL have Z80 bus inputs A in 16, mreq_n in 1, rd_n in 1, wr_n in 1, cpu_dout in 8, and output cpu_din out 8.
REQ-008 SHALL have main side latch_data in 8*NLATCH, latch_wr in NLATCH (one-clk strobes), latch_pend out NLATCH.
REQ-009 SHALL have nmi_n out 1, the interrupt to the sound CPU.
REQ-010 SHALL have device ports fm_cs out 1, oki_cs out 1, fm_dout in 8, oki_dout in 8, oki_ss out 1, dev_wrn out 1 (active-low write strobe).
REQ-011 SHALL have RAM ports ram_addr out RAMAW, ram_we out 1, ram_dout in 8.
REQ-012 SHALL have ROM ports rom_addr out 15+BANKW, rom_cs out 1, rom_data in 8, rom_ok in 1.

Function
REQ-013 SHALL decode, registered one clk after A: 0000-7FFF fixed ROM; 8000-BFFF banked ROM (ROM only on mreq_n=0 and rd_n=0); D000-DFFF RAM; F000-FFFF IO.
REQ-014 SHALL select IO by A[3:1]: 0 FM, 1 OKI, 2 bank, 3 oki_ss, 4..4+NLATCH-1 latch i; other codes are unmapped.
REQ-015 SHALL drive rom_addr = A[14:0] zero-extended for the fixed region, and 32768 + bank*16384 + A[13:0] for the banked region.
REQ-016 SHALL latch bank <= cpu_dout[BANKW-1:0] and oki_ss <= cpu_dout[0] on cen with wr_n=0 and the matching select.
REQ-017 SHALL drive dev_wrn = 0 only while (fm_cs|oki_cs) and wr_n=0 and mreq_n=0; ram_we = ram select and wr_n=0 and mreq_n=0.
REQ-018 SHALL latch latch_data[8i+7:8i] into internal latch i and set latch_pend[i] one clk after latch_wr[i].
REQ-019 SHALL clear latch_pend[i] on a cen cycle with rd_n=0 selecting latch i.
REQ-020 SHALL keep latch_pend[i]=1 with the new data when latch_wr[i] and the clearing read coincide (write wins).
REQ-021 SHALL form cpu_din by a two-stage registered mux: valid 2 clk after decode, priority device > latch > memory, 8'hFF when nothing is selected.
REQ-022 SHALL hold cpu_cen = cen & ~rom_wait; rom_wait = rom_cs && !(rom_ok high on two consecutive clks), so the CPU stalls until ROM data is stable.
REQ-023 SHALL leave the latch state unchanged by repeated reads without an intervening write.

Reset
REQ-024 SHALL on rst reset bank=0, oki_ss=0, latches=8'h00, latch_pend=0, all selects=0, cpu_din=8'hFF, nmi_n=1, dev_wrn=1, ram_we=0.
REQ-025 SHALL abort any pending ROM wait when rst is asserted mid-access and restart cleanly after release.

Configuration
REQ-026 SHALL, with JTCPS_SNDBUS_NMI_EN defined, drive nmi_n = ~|latch_pend (low while any latch is pending).
REQ-027 SHALL, without JTCPS_SNDBUS_NMI_EN defined, tie nmi_n to 1 and leave the CPU to poll latch_pend.

Structure
REQ-028 SHALL place the memory-map base constants and the IO select codes in shared package jtcps_snd_pkg.
REQ-029 SHALL implement the latch bank and its pend/NMI logic in sub-module jtcps_sndlatch, instantiated once with NLATCH.

Verification
REQ-030 SHALL cover: BANKW=2, write 3 to F004, read A=8123 -> rom_addr=0x14123 with rom_cs=1.
REQ-031 SHALL cover: latch_wr[1] with data 0x5A -> latch_pend=2'b10, nmi_n=0 (macro defined); Z80 read F00A -> cpu_din=0x5A, then pend=0, nmi_n=1.
REQ-032 SHALL cover: latch_wr[0] on the same clk as a read of F008 -> pend[0] stays 1, the next read returns the new data.
REQ-033 SHALL cover: rom_ok held low 10 clks during a ROM fetch -> cpu_cen=0 throughout, resuming 2 clks after rom_ok rises.
REQ-034 SHALL cover: read of unmapped F00E (NLATCH=2) -> cpu_din=0xFF; write to F002 -> dev_wrn=0, oki_cs=1.
REQ-035 SHALL cover: rst asserted during a ROM wait -> all outputs return to the REQ-024 values within 1 clk.
